// File: rtl/cpu_decode_queue.sv
// Decode stage between fetch and control: decodes each fetched word as it is
// enqueued and buffers {id, illegal, instr, pc} in a small FIFO.
module cpu_decode_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 6,
  parameter bit          EN_EXT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [31:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_illegal,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ID_W-1:0] ILL_ID = '1;

  logic [5:0]      op;
  logic [5:0]      fn;
  logic            b23;
  logic [ID_W-1:0] dec_id_c;
  logic            dec_ill_c;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_c;
  logic             pop_c;

  logic [ID_W-1:0] mem_id    [DEPTH];
  logic            mem_ill   [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [31:0]     mem_pc    [DEPTH];

  assign op  = in_instr[31:26];
  assign fn  = in_instr[5:0];
  assign b23 = in_instr[23];

  // Combinational decode of the incoming word into an instruction ID.
  always_comb begin
    dec_id_c = ILL_ID;
    case (op)
      6'h00: begin
        case (fn)
          6'h21: dec_id_c = ID_W'(0);
          6'h20: dec_id_c = ID_W'(1);
          6'h23: dec_id_c = ID_W'(2);
          6'h22: dec_id_c = ID_W'(3);
          6'h24: dec_id_c = ID_W'(4);
          6'h25: dec_id_c = ID_W'(5);
          6'h26: dec_id_c = ID_W'(6);
          6'h27: dec_id_c = ID_W'(7);
          6'h2A: dec_id_c = ID_W'(8);
          6'h2B: dec_id_c = ID_W'(9);
          6'h00: dec_id_c = ID_W'(10);
          6'h02: dec_id_c = ID_W'(11);
          6'h03: dec_id_c = ID_W'(12);
          6'h04: dec_id_c = ID_W'(13);
          6'h06: dec_id_c = ID_W'(14);
          6'h07: dec_id_c = ID_W'(15);
          6'h08: dec_id_c = ID_W'(16);
          6'h09: dec_id_c = ID_W'(17);
          6'h10: dec_id_c = ID_W'(18);
          6'h12: dec_id_c = ID_W'(19);
          6'h11: dec_id_c = ID_W'(20);
          6'h13: dec_id_c = ID_W'(21);
          6'h19: dec_id_c = ID_W'(26);
          6'h1A: dec_id_c = ID_W'(27);
          6'h1B: dec_id_c = ID_W'(28);
          6'h0D: dec_id_c = ID_W'(50);
          6'h0C: dec_id_c = ID_W'(51);
          6'h34: dec_id_c = ID_W'(53);
          default: dec_id_c = ILL_ID;
        endcase
      end
      6'h1C: begin
        if (fn == 6'h20)      dec_id_c = ID_W'(24);
        else if (fn == 6'h02) dec_id_c = ID_W'(25);
      end
      6'h10: begin
        if (fn == 6'h00)      dec_id_c = b23 ? ID_W'(23) : ID_W'(22);
        else if (fn == 6'h18) dec_id_c = ID_W'(52);
      end
      6'h08: dec_id_c = ID_W'(29);
      6'h09: dec_id_c = ID_W'(30);
      6'h0C: dec_id_c = ID_W'(31);
      6'h0D: dec_id_c = ID_W'(32);
      6'h0E: dec_id_c = ID_W'(33);
      6'h0F: dec_id_c = ID_W'(34);
      6'h23: dec_id_c = ID_W'(35);
      6'h20: dec_id_c = ID_W'(36);
      6'h24: dec_id_c = ID_W'(37);
      6'h21: dec_id_c = ID_W'(38);
      6'h25: dec_id_c = ID_W'(39);
      6'h2B: dec_id_c = ID_W'(40);
      6'h28: dec_id_c = ID_W'(41);
      6'h29: dec_id_c = ID_W'(42);
      6'h04: dec_id_c = ID_W'(43);
      6'h05: dec_id_c = ID_W'(44);
      6'h01: dec_id_c = ID_W'(45);
      6'h0A: dec_id_c = ID_W'(46);
      6'h0B: dec_id_c = ID_W'(47);
      6'h02: dec_id_c = ID_W'(48);
      6'h03: dec_id_c = ID_W'(49);
      default: dec_id_c = ILL_ID;
    endcase
    // Extension group (clz..divu) is reserved when extensions are disabled.
    if (!EN_EXT && (dec_id_c >= ID_W'(24)) && (dec_id_c <= ID_W'(28))) begin
      dec_id_c = ILL_ID;
    end
  end

  assign dec_ill_c = (dec_id_c == ILL_ID);

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push_c    = in_valid & in_ready & ~flush;
  assign pop_c     = out_valid & out_ready & ~flush;

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_id[wr_ptr]    <= dec_id_c;
      mem_ill[wr_ptr]   <= dec_ill_c;
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  // Pointer and occupancy tracking; flush discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head view, gated to fixed values when nothing is held.
  assign out_id      = out_valid ? mem_id[rd_ptr]    : ILL_ID;
  assign out_illegal = out_valid ? mem_ill[rd_ptr]   : 1'b0;
  assign out_instr   = out_valid ? mem_instr[rd_ptr] : 32'h0;
  assign out_pc      = out_valid ? mem_pc[rd_ptr]    : 32'h0;

endmodule

// File: tb/tb_cpu_decode_queue.sv
// Self-checking bench for cpu_decode_queue: one instance with extensions
// enabled and one with them disabled, both driven by the same stimulus.
module tb_cpu_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int ILL = 63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        in_ready1, out_valid1, out_illegal1;
  logic [5:0]  out_id1;
  logic [31:0] out_instr1, out_pc1;
  logic [2:0]  count1;
  logic        in_ready0, out_valid0, out_illegal0;
  logic [5:0]  out_id0;
  logic [31:0] out_instr0, out_pc0;
  logic [2:0]  count0;

  int n_vec = 0;
  int n_bad = 0;

  cpu_decode_queue #(.DEPTH(DEPTH), .ID_W(6), .EN_EXT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid1), .out_ready(out_ready), .out_id(out_id1),
    .out_illegal(out_illegal1), .out_instr(out_instr1), .out_pc(out_pc1),
    .count(count1)
  );

  cpu_decode_queue #(.DEPTH(DEPTH), .ID_W(6), .EN_EXT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid0), .out_ready(out_ready), .out_id(out_id0),
    .out_illegal(out_illegal0), .out_instr(out_instr0), .out_pc(out_pc0),
    .count(count0)
  );

  always #5 clk = ~clk;

  // Reference decode: lookup tables keyed by funct (op=0) and by opcode.
  int fn_map [64];
  int op_map [64];

  task automatic init_maps();
    int r_fn [28] = '{6'h21, 6'h20, 6'h23, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                      6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                      6'h08, 6'h09, 6'h10, 6'h12, 6'h11, 6'h13, 6'h19, 6'h1A,
                      6'h1B, 6'h0D, 6'h0C, 6'h34};
    int r_id [28] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                      16, 17, 18, 19, 20, 21, 26, 27, 28, 50, 51, 53};
    int i_op [21] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h20,
                      6'h24, 6'h21, 6'h25, 6'h2B, 6'h28, 6'h29, 6'h04, 6'h05,
                      6'h01, 6'h0A, 6'h0B, 6'h02, 6'h03};
    for (int k = 0; k < 64; k++) begin
      fn_map[k] = -1;
      op_map[k] = -1;
    end
    for (int k = 0; k < 28; k++) fn_map[r_fn[k]] = r_id[k];
    for (int k = 0; k < 21; k++) op_map[i_op[k]] = 29 + k;
  endtask

  function automatic int model_id(input logic [31:0] w, input bit ext);
    int id;
    int op;
    int fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    if (op == 0)            id = fn_map[fn];
    else if (op == 'h1C)    id = (fn == 'h20) ? 24 : ((fn == 'h02) ? 25 : -1);
    else if (op == 'h10)    id = (fn == 0) ? (w[23] ? 23 : 22) : ((fn == 'h18) ? 52 : -1);
    else                    id = op_map[op];
    if (id < 0) id = ILL;
    if (!ext && id >= 24 && id <= 28) id = ILL;
    return id;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          id1;
    int          id0;
  } ent_t;

  ent_t q[$];

  // Compare every observable output of both instances against the model.
  task automatic check_state(input string name);
    bit          bad;
    int          ec;
    logic        ev, er, ei1, ei0;
    int          eid1, eid0;
    logic [31:0] einstr, epc;
    ec = q.size();
    ev = (ec != 0);
    er = (ec < int'(DEPTH));
    if (ev) begin
      eid1 = q[0].id1; eid0 = q[0].id0;
      ei1 = (eid1 == ILL); ei0 = (eid0 == ILL);
      einstr = q[0].instr; epc = q[0].pc;
    end else begin
      eid1 = ILL; eid0 = ILL; ei1 = 1'b0; ei0 = 1'b0; einstr = '0; epc = '0;
    end
    bad = (out_valid1 !== ev) || (in_ready1 !== er) || (count1 !== 3'(ec)) ||
          (out_id1 !== 6'(eid1)) || (out_illegal1 !== ei1) ||
          (out_instr1 !== einstr) || (out_pc1 !== epc) ||
          (out_valid0 !== ev) || (in_ready0 !== er) || (count0 !== 3'(ec)) ||
          (out_id0 !== 6'(eid0)) || (out_illegal0 !== ei0) ||
          (out_instr0 !== einstr) || (out_pc0 !== epc);
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s t=%0t got v=%b r=%b c=%0d id=%0d ill=%b ins=%h pc=%h id0=%0d ill0=%b c0=%0d | exp v=%b r=%b c=%0d id=%0d ill=%b ins=%h pc=%h id0=%0d ill0=%b",
               name, $time, out_valid1, in_ready1, count1, out_id1, out_illegal1, out_instr1,
               out_pc1, out_id0, out_illegal0, count0, ev, er, ec, eid1, ei1, einstr, epc,
               eid0, ei0);
    end
  endtask

  // One clock: check the pre-edge state, then advance the model across the edge.
  task automatic cycle(input string name);
    bit   push;
    bit   pop;
    ent_t e;
    check_state(name);
    push = in_valid && (q.size() < int'(DEPTH));
    pop  = out_ready && (q.size() > 0);
    e.instr = in_instr;
    e.pc    = in_pc;
    e.id1   = model_id(in_instr, 1'b1);
    e.id0   = model_id(in_instr, 1'b0);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop)  q.delete(0);
      if (push) q.push_back(e);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 3);
    case (k)
      0: w[31:26] = 6'h00;
      1: begin
        w[31:26] = 6'h1C;
        if ($urandom_range(0, 1) == 1) w[5:0] = ($urandom_range(0, 1) == 1) ? 6'h20 : 6'h02;
      end
      2: begin
        w[31:26] = 6'h10;
        if ($urandom_range(0, 1) == 1) w[5:0] = ($urandom_range(0, 1) == 1) ? 6'h18 : 6'h00;
      end
      default: ;
    endcase
    return w;
  endfunction

  typedef struct {
    logic [31:0] instr;
    int          id1;
    int          id0;
  } vec_t;

  vec_t tbl [30];

  initial begin
    tbl = '{
      '{32'h00221820,  1,  1}, '{32'h00221821,  0,  0}, '{32'h00221823,  2,  2},
      '{32'h00000000, 10, 10}, '{32'h03E00008, 16, 16}, '{32'h0000000C, 51, 51},
      '{32'h0000000D, 50, 50}, '{32'h00000034, 53, 53}, '{32'h00000019, 26, 63},
      '{32'h0000001A, 27, 63}, '{32'h0000001B, 28, 63}, '{32'h70001020, 24, 63},
      '{32'h70001002, 25, 63}, '{32'h40016000, 22, 22}, '{32'h40816000, 23, 23},
      '{32'h42000018, 52, 52}, '{32'hFC000000, 63, 63}, '{32'h0000003F, 63, 63},
      '{32'h7000003F, 63, 63}, '{32'h40000001, 63, 63}, '{32'h8C010004, 35, 35},
      '{32'h3C011234, 34, 34}, '{32'h04010002, 45, 45}, '{32'h08000010, 48, 48},
      '{32'h0C000010, 49, 49}, '{32'h2C000001, 47, 47}, '{32'hA4000000, 42, 42},
      '{32'h10000000, 43, 43}, '{32'h90000000, 37, 37}, '{32'h00000010, 18, 18}
    };
    init_maps();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: one word per cycle, consumer always ready, head = last push.
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_instr = tbl[i].instr; in_pc = 32'h100 + 32'(4 * i);
      cycle("table_push");
      n_vec++;
      if (out_valid1 !== 1'b1 || out_id1 !== 6'(tbl[i].id1) ||
          out_illegal1 !== (tbl[i].id1 == ILL) || out_id0 !== 6'(tbl[i].id0) ||
          out_illegal0 !== (tbl[i].id0 == ILL) || out_pc1 !== 32'h100 + 32'(4 * i) ||
          out_instr1 !== tbl[i].instr) begin
        n_bad++;
        $display("FAIL table[%0d] instr=%h got v=%b id=%0d ill=%b id0=%0d ill0=%b pc=%h exp id=%0d id0=%0d",
                 i, tbl[i].instr, out_valid1, out_id1, out_illegal1, out_id0, out_illegal0,
                 out_pc1, tbl[i].id1, tbl[i].id0);
      end
    end
    in_valid = 1'b0;
    cycle("table_drain");
    cycle("table_empty");

    // Fill past capacity with the consumer stalled, then stream across the wrap.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h2000 + 32'(4 * i);
      cycle("fill");
    end
    check_state("full");
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_instr = rand_instr(); in_pc = 32'h3000 + 32'(4 * i);
      cycle("stream_wrap");
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle("drain");

    // Flush with a simultaneous push and pop: both must be suppressed.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'h00221821; in_pc = 32'h4000 + 32'(4 * i);
      cycle("pre_flush");
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h3C01DEAD; in_pc = 32'h4444;
    cycle("flush");
    flush = 1'b0; in_valid = 1'b0;
    cycle("post_flush");
    in_valid = 1'b1; in_instr = 32'h8C010004; in_pc = 32'h5000;
    cycle("post_flush_push");
    in_valid = 1'b0;
    cycle("post_flush_head");
    cycle("post_flush_empty");

    // Asynchronous reset between edges while holding two entries.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'h00000019; in_pc = 32'h6000 + 32'(4 * i);
      cycle("pre_reset");
    end
    in_valid = 1'b0;
    check_state("pre_reset_hold");
    rst_n = 1'b0;
    #2;
    q.delete();
    check_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset_idle");
    in_valid = 1'b1; in_instr = 32'h42000018; in_pc = 32'h7000;
    cycle("post_reset_push");
    in_valid = 1'b0;
    cycle("post_reset_head");

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      cycle("random");
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
